// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time and a small
// FIFO of fetched {pc, instruction} pairs, flushed on branch/jump redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_next_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_nxt;
  logic [31:0]       r_pending_pc;
  logic [31:0]       r_buf_data [BUF_DEPTH];
  logic [31:0]       r_buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_redirect_pc;
  logic              w_unused_redirect_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR_C) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // A redirect target is always forced onto a word boundary.
  assign w_redirect_pc         = {redirect_pc[31:2], 2'b00};
  assign w_unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  assign w_req_valid = (r_state == FETCH) && (r_count < DEPTH_C) && !redirect_valid && !rst;
  assign w_req_fire  = w_req_valid && imem_req_ready;
  // Responses only land in the buffer when they answer a live request.
  assign w_push      = (r_state == WAIT_RSP) && imem_rsp_valid && !redirect_valid;
  assign w_pop       = inst_valid && inst_ready && !redirect_valid;

  // Next-state and next-PC selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end else if (w_req_fire) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = WAIT_RSP;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      WAIT_RSP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
          if (imem_rsp_valid) begin
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (imem_rsp_valid) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = WAIT_RSP;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        // Once the abandoned response shows up nothing is outstanding any more.
        if (imem_rsp_valid) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = r_pc;
      end
    endcase
  end

  // State, PC and pending-request address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_req_fire) begin
        r_pending_pc <= r_pc;
      end
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_data[i] <= 32'd0;
        r_buf_pc[i]   <= 32'd0;
      end
    end else if (w_push) begin
      r_buf_data[r_wr_ptr] <= imem_rsp_data;
      r_buf_pc[r_wr_ptr]   <= r_pending_pc;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_count != {CNT_W{1'b0}});
  assign inst_data      = r_buf_data[r_rd_ptr];
  assign inst_pc        = r_buf_pc[r_rd_ptr];
  assign inst_next_pc   = r_buf_pc[r_rd_ptr] + 32'd4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; fixed at 2 for this release.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  fetch word address, bits[1:0] always 0.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_rsp_valid  input  1  memory returns instruction word.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  one-cycle PC redirect from branch/jump resolution.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 inst_valid  output  1  buffer head valid.
REQ-013 inst_data  output  32  head instruction.
REQ-014 inst_pc  output  32  head instruction address.
REQ-015 inst_next_pc  output  32  inst_pc + 4, sequential successor fed to branch target computation.
REQ-016 inst_ready  input  1  consumer accepts head.

Function
REQ-017 State machine SHALL have states FETCH, WAIT_RSP, DRAIN; at most one request outstanding.
REQ-018 In FETCH, imem_req_valid SHALL be 1 iff (buffer count + 0 outstanding) < BUF_DEPTH and redirect_valid = 0.
REQ-019 imem_req_addr SHALL equal the PC register; addr SHALL hold stable while valid and not ready.
REQ-020 On request handshake (valid & ready) the unit SHALL latch pending_pc = PC, set PC = PC + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), and enter WAIT_RSP.
REQ-021 In WAIT_RSP, imem_req_valid SHALL be 0; on imem_rsp_valid the entry {pending_pc, imem_rsp_data} SHALL be pushed to the buffer and state SHALL return to FETCH; earliest next request is the following cycle.
REQ-022 imem_rsp_valid in FETCH (nothing outstanding) SHALL be ignored.
REQ-023 Buffer SHALL be FIFO; inst_valid = count != 0; inst_data/inst_pc/inst_next_pc SHALL reflect the head entry combinationally; pop on inst_valid & inst_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order; push into a full buffer SHALL not occur by construction of REQ-018 (asserted in verification).
REQ-025 On redirect_valid the unit SHALL flush the buffer (count = 0), set PC = {redirect_pc[31:2], 2'b00}, and deassert imem_req_valid that cycle.
REQ-026 Redirect while a request is outstanding (state WAIT_RSP without rsp that cycle, or handshake in that same cycle—prevented by REQ-018) SHALL enter DRAIN; DRAIN SHALL discard the next imem_rsp_valid and then enter FETCH.
REQ-027 Redirect in WAIT_RSP coinciding with imem_rsp_valid SHALL discard that response and enter FETCH directly.
REQ-028 Redirect has priority over push and pop in the same cycle; a pop in the redirect cycle is dropped, not delivered.
REQ-029 Redirect received in DRAIN SHALL update PC and remain in DRAIN.
REQ-030 Fetched latency: instruction from a request accepted at cycle N with response at cycle M SHALL show inst_valid at cycle M+1.

Reset
REQ-031 While rst = 1 at a clock edge: PC = RESET_PC, state = FETCH, buffer count = 0, pending_pc = 0.
REQ-032 Reset outputs: imem_req_valid = 0 during reset cycle, inst_valid = 0, imem_req_addr = RESET_PC, inst_data/inst_pc = 0, inst_next_pc = 4.
REQ-033 Reset mid-operation SHALL abandon any outstanding request; a later stale response SHALL be ignored per REQ-022.

Verification
REQ-034 Reset release, ready=1, rsp one cycle after each request, inst_ready=1 -> requests at addr 0x0,0x4,0x8 in order; inst_pc 0x0,0x4 with inst_next_pc 0x4,0x8.
REQ-035 inst_ready=0, memory always responds -> exactly 2 entries buffered, imem_req_valid stays 0 afterward; raising inst_ready drains 0x0 then 0x4, fetching resumes at 0x8.
REQ-036 Redirect to 0x0000_0103 while in WAIT_RSP for 0x10 -> buffer empties, response for 0x10 discarded, next request addr 0x0000_0100.
REQ-037 RESET_PC = 32'hFFFF_FFFC -> first request 0xFFFF_FFFC, second 0x0000_0000; inst_next_pc of first = 0x0.
REQ-038 imem_req_ready held 0 for 5 cycles -> imem_req_addr stable at 0x0 all 5 cycles; redirect to 0x40 in cycle 3 -> valid drops that cycle, next request addr 0x40, no DRAIN.
